// File: rtl/mc_datapath_hs.sv
// Multicycle RV32 datapath with a ready/valid memory port: wait-state/timeout access FSM,
// strobed sub-word stores, sign/zero-extended loads and a parametrised register file.
module mc_datapath_hs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        PCWrite,
  input  logic        AdrSrc,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic        RegWrite,
  input  logic [1:0]  ResultSrc,
  input  logic [1:0]  ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [2:0]  ALUControl,
  input  logic [2:0]  ImmSrc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic        Zero,
  output logic        mem_busy,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int RW = (NREGS == 16) ? 4 : 5;

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t      r_state;
  logic [31:0] r_pc, r_oldpc, r_ir, r_data, r_a, r_wd, r_aluout;
  logic [31:0] r_rf [NREGS];
  logic        r_fetch, r_valid, r_we, r_misalign, r_bus_err;
  logic [2:0]  r_f3;
  logic [1:0]  r_lo;
  logic [15:0] r_wait;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_strb;

  logic [RW-1:0] w_ra1, w_ra2, w_rd;
  logic [31:0]   w_rd1, w_rd2, w_imm, w_srca, w_srcb, w_alu, w_result, w_adr;
  logic          w_accept, w_busy, w_mis, w_timeout;

  function automatic logic [3:0] f_strb(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lo, 3'b000} +: 8];
    h = lo[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h00_0000, b};
      3'b101:  return {16'h0000, h};
      default: return d;
    endcase
  endfunction

  assign w_ra1 = r_ir[15 +: RW];
  assign w_ra2 = r_ir[20 +: RW];
  assign w_rd  = r_ir[7 +: RW];
  assign w_rd1 = (w_ra1 == '0) ? 32'h0000_0000 : r_rf[w_ra1];
  assign w_rd2 = (w_ra2 == '0) ? 32'h0000_0000 : r_rf[w_ra2];

  // Immediate extender, ALU operand muxes, ALU and result mux
  always_comb begin
    case (ImmSrc)
      3'b000:  w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
      3'b001:  w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      3'b010:  w_imm = {{20{r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      3'b011:  w_imm = {{12{r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
      3'b100:  w_imm = {r_ir[31:12], 12'h000};
      default: w_imm = 32'h0000_0000;
    endcase
    case (ALUSrcA)
      2'b00:   w_srca = r_pc;
      2'b01:   w_srca = r_oldpc;
      2'b10:   w_srca = r_a;
      default: w_srca = 32'h0000_0000;
    endcase
    case (ALUSrcB)
      2'b00:   w_srcb = r_wd;
      2'b01:   w_srcb = w_imm;
      2'b10:   w_srcb = 32'h0000_0004;
      default: w_srcb = 32'h0000_0000;
    endcase
    case (ALUControl)
      3'b000:  w_alu = w_srca + w_srcb;
      3'b001:  w_alu = w_srca - w_srcb;
      3'b010:  w_alu = w_srca & w_srcb;
      3'b011:  w_alu = w_srca | w_srcb;
      3'b100:  w_alu = w_srca ^ w_srcb;
      3'b101:  w_alu = {31'h0000_0000, $signed(w_srca) < $signed(w_srcb)};
      3'b110:  w_alu = w_srca << w_srcb[4:0];
      default: w_alu = w_srca >> w_srcb[4:0];
    endcase
    case (ResultSrc)
      2'b00:   w_result = r_aluout;
      2'b01:   w_result = r_data;
      2'b10:   w_result = w_alu;
      default: w_result = 32'h0000_0000;
    endcase
  end

  assign w_adr     = AdrSrc ? w_result : r_pc;
  assign w_accept  = MemReq && (r_state == S_IDLE);
  assign w_busy    = (r_state == S_REQ) || w_accept;
  // Instruction fetches are never flagged; only data accesses need natural alignment.
  assign w_mis     = !IRWrite && (((r_ir[13:12] == 2'b01) && w_adr[0]) ||
                                  (r_ir[13] && (w_adr[1:0] != 2'b00)));
  assign w_timeout = (TIMEOUT != 0) && (r_wait == 16'(TIMEOUT));

  // Memory-access FSM: request latch, wait/timeout handling and IR/Data capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_ir       <= 32'h0000_0013;
      r_oldpc    <= RESET_PC;
      r_data     <= 32'h0000_0000;
      r_fetch    <= 1'b0;
      r_f3       <= 3'b000;
      r_lo       <= 2'b00;
      r_valid    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'h0000_0000;
      r_strb     <= 4'h0;
      r_wdata    <= 32'h0000_0000;
      r_wait     <= 16'h0000;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MemReq) begin
            r_fetch    <= IRWrite;
            r_f3       <= r_ir[14:12];
            r_lo       <= w_adr[1:0];
            r_misalign <= w_mis;
            if (!w_mis) begin
              r_state <= S_REQ;
              r_valid <= 1'b1;
              r_we    <= MemWrite;
              r_addr  <= {w_adr[31:2], 2'b00};
              r_strb  <= MemWrite ? f_strb(r_ir[13:12], w_adr[1:0]) : 4'h0;
              r_wdata <= f_wdata(r_ir[13:12], r_wd);
              r_wait  <= 16'h0000;
            end
          end
        end
        S_REQ: begin
          if (mem_ready || w_timeout) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_strb  <= 4'h0;
            if (!mem_ready) begin
              r_bus_err <= 1'b1;
            end else if (r_fetch) begin
              r_ir    <= mem_rdata;
              r_oldpc <= r_pc;
            end else if (!r_we) begin
              r_data <= f_load(r_f3, r_lo, mem_rdata);
            end
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // PC and per-cycle A/WriteData/ALUOut pipeline registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc     <= RESET_PC;
      r_a      <= 32'h0000_0000;
      r_wd     <= 32'h0000_0000;
      r_aluout <= 32'h0000_0000;
    end else begin
      if (PCWrite && !w_busy) r_pc <= w_result;
      r_a      <= w_rd1;
      r_wd     <= w_rd2;
      r_aluout <= w_alu;
    end
  end

  // Register file write port; x0 stays zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= 32'h0000_0000;
    end else if (RegWrite && !w_busy && (w_rd != '0)) begin
      r_rf[w_rd] <= w_result;
    end
  end

  assign op        = r_ir[6:0];
  assign funct3    = r_ir[14:12];
  assign funct7b5  = r_ir[30];
  assign Zero      = (w_alu == 32'h0000_0000);
  assign mem_busy  = w_busy;
  assign misalign  = r_misalign;
  assign bus_err   = r_bus_err;
  assign mem_valid = r_valid;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wstrb = r_strb;
  assign mem_wdata = r_wdata;
endmodule

// File: tb/tb_mc_datapath_hs.sv
// Randomised self-checking bench for mc_datapath_hs against an instruction-level reference model.
module tb_mc_datapath_hs;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          TO  = 4;

  logic        clk = 1'b0, resetn;
  logic        PCWrite, AdrSrc, MemReq, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ALUControl, ImmSrc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, Zero, mem_busy, misalign, bus_err, mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  mc_datapath_hs #(.RESET_PC(RPC), .NREGS(32), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemReq(MemReq),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero), .mem_busy(mem_busy),
    .misalign(misalign), .bus_err(bus_err), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_pass = 0;
  logic [31:0] m_pc, m_ir, m_data;
  logic [31:0] m_rf [32];
  bit          m_bus_err, m_mis;
  logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle_in();
    PCWrite = 1'b0; AdrSrc = 1'b0; MemReq = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
    RegWrite = 1'b0; ResultSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00;
    ALUControl = 3'b000; ImmSrc = 3'b000; mem_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = RPC; m_ir = 32'h0000_0013; m_data = 32'h0; m_bus_err = 1'b0; m_mis = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
  endtask

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

  // Load result: pick the addressed byte/half arithmetically, then extend
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * lo)) & 32'h0000_00FF;
    h = (d >> (16 * lo[1])) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  // One memory access: MemReq cycle, then ready after 'delay' wait cycles (or timeout)
  task automatic access(input bit fetch, input bit store, input logic [2:0] isrc,
                        input logic [31:0] adr, input int delay, input logic [31:0] rdata);
    logic [31:0] rs2v, ewd;
    logic [3:0]  estrb;
    logic [2:0]  f3;
    bit          mis, rdy, tmo;
    f3    = m_ir[14:12];
    rs2v  = m_rf[m_ir[24:20]];
    mis   = !fetch && ((f3[1:0] == 2'b01 && adr[0]) || (f3[1] && adr[1:0] != 2'b00));
    estrb = 4'h0;
    ewd   = 32'h0;
    if (store) begin
      if (f3[1:0] == 2'b00) begin
        estrb = 4'(1 << adr[1:0]); ewd = (rs2v & 32'hFF) * 32'h0101_0101;
      end else if (f3[1:0] == 2'b01) begin
        estrb = 4'(3 << (2 * adr[1])); ewd = (rs2v & 32'hFFFF) * 32'h0001_0001;
      end else begin
        estrb = 4'hF; ewd = rs2v;
      end
    end
    idle_in();
    MemReq = 1'b1; IRWrite = fetch; MemWrite = store; PCWrite = 1'b1;
    if (!fetch) begin
      AdrSrc = 1'b1; ALUSrcA = 2'b11; ALUSrcB = 2'b01; ImmSrc = isrc; ResultSrc = 2'b10;
    end
    #1 chk("busy_memreq", 32'(mem_busy), 32'd1);
    step();
    idle_in();
    #1;
    m_mis = mis;
    chk("misalign", 32'(misalign), 32'(m_mis));
    if (mis) begin
      chk("valid_misaligned", 32'(mem_valid), 32'd0);
      chk("busy_misaligned", 32'(mem_busy), 32'd0);
      step();
      chk("valid_misaligned2", 32'(mem_valid), 32'd0);
      return;
    end
    rdy = 1'b0;
    tmo = 1'b0;
    for (int k = 0; k <= TO; k++) begin
      chk("valid", 32'(mem_valid), 32'd1);
      chk("addr", mem_addr, {adr[31:2], 2'b00});
      chk("wstrb", 32'(mem_wstrb), 32'(estrb));
      chk("we", 32'(mem_we), 32'(store));
      chk("busy_wait", 32'(mem_busy), 32'd1);
      if (store) chk("wdata", mem_wdata, ewd);
      rdy = (k == delay);
      tmo = !rdy && (k == TO);
      mem_ready = rdy;
      mem_rdata = rdy ? rdata : $urandom();
      PCWrite = 1'b1; RegWrite = 1'b1; MemReq = 1'b1; ResultSrc = 2'b10;
      step();
      idle_in();
      #1;
      if (rdy || tmo) break;
    end
    if (rdy && fetch) m_ir = rdata;
    else if (rdy && !store) m_data = load_ext(f3, adr[1:0], rdata);
    if (tmo) m_bus_err = 1'b1;
    chk("valid_after", 32'(mem_valid), 32'd0);
    chk("busy_after", 32'(mem_busy), 32'd0);
    chk("bus_err", 32'(bus_err), 32'(m_bus_err));
  endtask

  task automatic fetch(input logic [31:0] instr, input int delay);
    access(1'b1, 1'b0, 3'b000, m_pc, delay, instr);
    chk("op", 32'(op), 32'(m_ir[6:0]));
    chk("funct3", 32'(funct3), 32'(m_ir[14:12]));
    chk("funct7b5", 32'(funct7b5), 32'(m_ir[30]));
    step();
  endtask

  task automatic wb();
    idle_in(); RegWrite = 1'b1; ResultSrc = 2'b01;
    step();
    idle_in();
    if (m_ir[11:7] != 5'd0) m_rf[m_ir[11:7]] = m_data;
  endtask

  task automatic pc_inc();
    idle_in(); PCWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
    #1 chk("zero", 32'(Zero), 32'(m_pc + 32'd4 == 32'd0));
    step();
    idle_in();
    m_pc = m_pc + 32'd4;
  endtask

  task automatic do_load(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] rdata, input int delay);
    fetch({imm, 5'($urandom()), f3, rd, 7'b0000011}, $urandom_range(TO, 0));
    access(1'b0, 1'b0, 3'b000, sext12(imm), delay, rdata);
    wb();
    pc_inc();
  endtask

  task automatic do_store(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rs2, input int delay);
    fetch({imm[11:5], rs2, 5'($urandom()), f3, imm[4:0], 7'b0100011}, $urandom_range(TO, 0));
    access(1'b0, 1'b1, 3'b001, sext12(imm), delay, 32'h0);
    pc_inc();
  endtask

  initial begin
    idle_in();
    mem_rdata = 32'h0;
    resetn = 1'b0;
    model_reset();
    repeat (3) step();
    resetn = 1'b1;
    step();
    chk("rst_op", 32'(op), 32'h13);
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_busy", 32'(mem_busy), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);

    // Directed: sub-word stores and extended loads
    do_load(12'h200, 3'd2, 5'd5, 32'h1122_3344, 0);
    do_store(12'h203, 3'd0, 5'd5, 2);
    do_store(12'h202, 3'd1, 5'd5, 1);
    do_load(12'h201, 3'd0, 5'd6, 32'h0000_8000, 1);
    do_store(12'h200, 3'd2, 5'd6, 0);
    do_load(12'h201, 3'd4, 5'd7, 32'h0000_8000, 0);
    do_store(12'h200, 3'd2, 5'd7, 0);
    do_load(12'h201, 3'd1, 5'd8, 32'hCAFE_BABE, 0);
    do_load(12'h000, 3'd2, 5'd0, 32'h0000_DEAD, 0);
    do_store(12'h004, 3'd2, 5'd0, 0);
    fetch(32'h0000_0013, TO);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(1, 0) == 0)
        do_load(12'($urandom()), ld_f3[$urandom_range(4, 0)], 5'($urandom()), $urandom(), $urandom_range(TO, 0));
      else
        do_store(12'($urandom()), 3'($urandom_range(2, 0)), 5'($urandom()), $urandom_range(TO, 0));
    end

    // Timeout: no ready at all leaves IR untouched and sets the sticky error
    fetch(32'h4000_5033, 99);
    do_load(12'h104, 3'd2, 5'd9, 32'h1234_5678, 1);
    do_store(12'h108, 3'd2, 5'd9, 0);

    // Reset in the middle of a request
    idle_in(); MemReq = 1'b1; IRWrite = 1'b1;
    step();
    idle_in();
    #1 chk("valid_before_rst", 32'(mem_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("valid_async_rst", 32'(mem_valid), 32'd0);
    chk("busy_async_rst", 32'(mem_busy), 32'd0);
    chk("op_async_rst", 32'(op), 32'h13);
    step();
    #3 resetn = 1'b1;
    step();
    fetch(32'h00A0_0093, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
